alu_arbiter: RTL and testbench

Two-port arbiter and sequencer that shares one registered ALU instance between two requesters. Each requester issues {op, A, B} over a valid/ready handshake. The block grants round-robin, drives the ALU operand ports from internal registers, waits the ALU pipeline latency, and returns result and status tagged with the requester ID over a valid/ready response channel. Exactly one operation is in flight at a time. The block sits between client logic and the ALU and owns all ALU operand/op inputs; ALU reset is wired externally.

---
 rtl/alu_arbiter.sv | 112 +++++++++++
 tb/tb_alu_arbiter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one registered ALU between two requesters and
// returns each result, tagged with the requester ID, over a valid/ready channel.
module alu_arbiter #(
    parameter int unsigned N       = 2,
    parameter int unsigned M       = 8,
    parameter int unsigned ALU_LAT = 1
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_req0_valid,
    input  logic [N-1:0] i_req0_op,
    input  logic [M-1:0] i_req0_arg_A,
    input  logic [M-1:0] i_req0_arg_B,
    input  logic         i_req1_valid,
    input  logic [N-1:0] i_req1_op,
    input  logic [M-1:0] i_req1_arg_A,
    input  logic [M-1:0] i_req1_arg_B,
    output logic         o_req0_ready,
    output logic         o_req1_ready,
    output logic [N-1:0] o_alu_op,
    output logic [M-1:0] o_alu_arg_A,
    output logic [M-1:0] o_alu_arg_B,
    input  logic [M-1:0] i_alu_result,
    input  logic [3:0]   i_alu_status,
    output logic         o_resp_valid,
    output logic         o_resp_id,
    output logic [M-1:0] o_resp_result,
    output logic [3:0]   o_resp_status,
    input  logic         i_resp_ready,
    output logic         o_busy
);

    localparam int unsigned CW = $clog2(ALU_LAT + 2);

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StResp
    } state_t;

    state_t         state_q, state_d;
    logic           ptr_q;      // 0: requester 0 favoured on a tie
    logic [CW-1:0]  cnt_q;
    logic [N-1:0]   op_q;
    logic [M-1:0]   arg_a_q, arg_b_q;
    logic           id_q;
    logic [M-1:0]   result_q;
    logic [3:0]     status_q;

    logic grant0, grant1, accept, wait_done, resp_hs;

    always_comb begin
        grant0    = i_req0_valid & (~i_req1_valid | ~ptr_q);
        grant1    = i_req1_valid & (~i_req0_valid |  ptr_q);
        o_req0_ready = (state_q == StIdle) & grant0;
        o_req1_ready = (state_q == StIdle) & grant1;
        accept    = o_req0_ready | o_req1_ready;
        wait_done = (state_q == StWait) & (cnt_q == '0);
        resp_hs   = (state_q == StResp) & i_resp_ready;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (accept)    state_d = StWait;
            StWait: if (wait_done) state_d = StResp;
            StResp: if (resp_hs)   state_d = StIdle;
            default:               state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q  <= StIdle;
            ptr_q    <= 1'b0;
            cnt_q    <= '0;
            op_q     <= '0;
            arg_a_q  <= '0;
            arg_b_q  <= '0;
            id_q     <= 1'b0;
            result_q <= '0;
            status_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                // Grant is one-hot, so requester 1 wins exactly when its ready is set.
                op_q    <= o_req1_ready ? i_req1_op    : i_req0_op;
                arg_a_q <= o_req1_ready ? i_req1_arg_A : i_req0_arg_A;
                arg_b_q <= o_req1_ready ? i_req1_arg_B : i_req0_arg_B;
                id_q    <= o_req1_ready;
                ptr_q   <= ~o_req1_ready;
                cnt_q   <= CW'(ALU_LAT);
            end else if (state_q == StWait && !wait_done) begin
                cnt_q <= cnt_q - 1'b1;
            end
            if (wait_done) begin
                result_q <= i_alu_result;
                status_q <= i_alu_status;
            end
        end
    end

    assign o_alu_op      = op_q;
    assign o_alu_arg_A   = arg_a_q;
    assign o_alu_arg_B   = arg_b_q;
    assign o_resp_valid  = (state_q == StResp);
    assign o_resp_id     = id_q;
    assign o_resp_result = result_q;
    assign o_resp_status = status_q;
    assign o_busy        = (state_q != StIdle);

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: one instance with ALU_LAT=1, one with ALU_LAT=3,
// each fed by a small pipelined ALU model.
module tb_alu_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // ALU model: {status, result}; status = {carry, zero, neg, 0}
    function automatic logic [11:0] alu_f(input logic [1:0] op, input logic [7:0] a,
                                          input logic [7:0] b);
        logic [8:0] s;
        logic [7:0] r;
        logic       c;
        s = 9'd0;
        c = 1'b0;
        case (op)
            2'd0: begin s = {1'b0, a} + {1'b0, b}; r = s[7:0]; c = s[8]; end
            2'd1: r = a - b;
            2'd2: r = a & b;
            default: r = a ^ b;
        endcase
        return {c, (r == 8'd0), r[7], 1'b0, r};
    endfunction

    // Instance A: ALU_LAT = 1
    logic       a_v0 = 0, a_v1 = 0, a_rdy0, a_rdy1, a_rv, a_rid, a_rr = 1, a_busy;
    logic [1:0] a_op0 = 0, a_op1 = 0, a_alu_op;
    logic [7:0] a_a0 = 0, a_b0 = 0, a_a1 = 0, a_b1 = 0, a_alu_a, a_alu_b, a_rres;
    logic [3:0] a_rst;
    logic [11:0] a_p1 = 12'd0;

    // Instance B: ALU_LAT = 3
    logic       b_v0 = 0, b_v1 = 0, b_rdy0, b_rdy1, b_rv, b_rid, b_rr = 1, b_busy;
    logic [1:0] b_op0 = 0, b_op1 = 0, b_alu_op;
    logic [7:0] b_a0 = 0, b_b0 = 0, b_a1 = 0, b_b1 = 0, b_alu_a, b_alu_b, b_rres;
    logic [3:0] b_rst;
    logic [11:0] b_p1 = 12'd0, b_p2 = 12'd0, b_p3 = 12'd0;

    always @(posedge clk) begin
        a_p1 <= alu_f(a_alu_op, a_alu_a, a_alu_b);
        b_p1 <= alu_f(b_alu_op, b_alu_a, b_alu_b);
        b_p2 <= b_p1;
        b_p3 <= b_p2;
    end

    alu_arbiter #(.N(2), .M(8), .ALU_LAT(1)) u_dut_a (
        .i_clk(clk), .i_reset(rst_n),
        .i_req0_valid(a_v0), .i_req0_op(a_op0), .i_req0_arg_A(a_a0), .i_req0_arg_B(a_b0),
        .i_req1_valid(a_v1), .i_req1_op(a_op1), .i_req1_arg_A(a_a1), .i_req1_arg_B(a_b1),
        .o_req0_ready(a_rdy0), .o_req1_ready(a_rdy1),
        .o_alu_op(a_alu_op), .o_alu_arg_A(a_alu_a), .o_alu_arg_B(a_alu_b),
        .i_alu_result(a_p1[7:0]), .i_alu_status(a_p1[11:8]),
        .o_resp_valid(a_rv), .o_resp_id(a_rid), .o_resp_result(a_rres),
        .o_resp_status(a_rst), .i_resp_ready(a_rr), .o_busy(a_busy)
    );

    alu_arbiter #(.N(2), .M(8), .ALU_LAT(3)) u_dut_b (
        .i_clk(clk), .i_reset(rst_n),
        .i_req0_valid(b_v0), .i_req0_op(b_op0), .i_req0_arg_A(b_a0), .i_req0_arg_B(b_b0),
        .i_req1_valid(b_v1), .i_req1_op(b_op1), .i_req1_arg_A(b_a1), .i_req1_arg_B(b_b1),
        .o_req0_ready(b_rdy0), .o_req1_ready(b_rdy1),
        .o_alu_op(b_alu_op), .o_alu_arg_A(b_alu_a), .o_alu_arg_B(b_alu_b),
        .i_alu_result(b_p3[7:0]), .i_alu_status(b_p3[11:8]),
        .o_resp_valid(b_rv), .o_resp_id(b_rid), .o_resp_result(b_rres),
        .o_resp_status(b_rst), .i_resp_ready(b_rr), .o_busy(b_busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advance until A presents a response, bounded at 20 cycles.
    task automatic wait_a();
        tick();
        for (int i = 0; i < 20 && !a_rv; i++) tick();
        check("a_resp_seen", a_rv, 1);
    endtask

    initial begin
        #2;
        check("rst_alu_op", a_alu_op, 0);
        check("rst_alu_a", a_alu_a, 0);
        check("rst_rv", a_rv, 0);
        check("rst_busy", a_busy, 0);
        check("rst_rdy", {a_rdy0, a_rdy1}, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        // Single request, ALU_LAT=1
        a_v0 = 1; a_op0 = 2'd0; a_a0 = 8'h02; a_b0 = 8'hFC;
        #1;
        check("t1_rdy0", a_rdy0, 1);
        check("t1_rdy1", a_rdy1, 0);
        tick();
        a_v0 = 0;
        check("t1_alu_op", a_alu_op, 0);
        check("t1_alu_a", a_alu_a, 8'h02);
        check("t1_alu_b", a_alu_b, 8'hFC);
        check("t1_busy", a_busy, 1);
        check("t1_rv_c1", a_rv, 0);
        tick();
        check("t1_rv_c2", a_rv, 0);
        tick();
        check("t1_rv_c3", a_rv, 1);
        check("t1_id", a_rid, 0);
        check("t1_res", a_rres, 8'hFE);
        check("t1_st", a_rst, 4'h2);
        tick();
        check("t1_idle_rv", a_rv, 0);
        check("t1_idle_busy", a_busy, 0);
        check("t1_operands_kept", a_alu_a, 8'h02);

        // Reset pulse, then both requesters held valid for four ops
        rst_n = 0;
        tick();
        rst_n = 1;
        a_v0 = 1; a_op0 = 2'd0; a_a0 = 8'h7E; a_b0 = 8'hFE;
        a_v1 = 1; a_op1 = 2'd0; a_a1 = 8'h7E; a_b1 = 8'hFC;
        #1;
        check("t2_rdy0", a_rdy0, 1);
        check("t2_rdy1", a_rdy1, 0);
        for (int k = 0; k < 4; k++) begin
            wait_a();
            check("t3_id", a_rid, k % 2);
            check("t3_res", a_rres, (k % 2) ? 8'h7A : 8'h7C);
            check("t3_st", a_rst, 4'h8);
            tick();
        end
        a_v0 = 0; a_v1 = 0;

        // Backpressure in RESP
        a_rr = 0;
        a_v1 = 1; a_op1 = 2'd1; a_a1 = 8'h05; a_b1 = 8'h03;
        #1;
        check("t4_rdy1", a_rdy1, 1);
        wait_a();
        a_v0 = 1;
        repeat (5) begin
            tick();
            check("t4_rv", a_rv, 1);
            check("t4_id", a_rid, 1);
            check("t4_res", a_rres, 8'h02);
            check("t4_st", a_rst, 4'h0);
            check("t4_rdy", {a_rdy0, a_rdy1}, 0);
            check("t4_busy", a_busy, 1);
        end
        a_rr = 1;
        tick();
        check("t4_rel_rv", a_rv, 0);
        check("t4_rel_busy", a_busy, 0);
        a_v0 = 0; a_v1 = 0;

        // Asynchronous reset mid-WAIT
        a_v0 = 1; a_op0 = 2'd3; a_a0 = 8'h55; a_b0 = 8'h0F;
        #1;
        tick();
        a_v0 = 0;
        check("t5_busy_pre", a_busy, 1);
        #3 rst_n = 0;
        #1;
        check("t5_alu_op", a_alu_op, 0);
        check("t5_alu_a", a_alu_a, 0);
        check("t5_alu_b", a_alu_b, 0);
        check("t5_rv", a_rv, 0);
        check("t5_rid", a_rid, 0);
        check("t5_rres", a_rres, 0);
        check("t5_rst", a_rst, 0);
        check("t5_busy", a_busy, 0);
        tick();
        rst_n = 1;
        repeat (10) begin
            tick();
            check("t5_quiet_rv", a_rv, 0);
        end
        a_v0 = 1; a_v1 = 1;
        #1;
        check("t5_ptr_rdy0", a_rdy0, 1);
        check("t5_ptr_rdy1", a_rdy1, 0);
        a_v0 = 0; a_v1 = 0;
        tick();

        // ALU_LAT=3 on instance B
        b_v0 = 1; b_op0 = 2'd2; b_a0 = 8'hF0; b_b0 = 8'h3C;
        #1;
        check("t6_rdy0", b_rdy0, 1);
        tick();
        b_v0 = 0;
        check("t6_alu_op", b_alu_op, 2);
        check("t6_alu_a", b_alu_a, 8'hF0);
        check("t6_alu_b", b_alu_b, 8'h3C);
        for (int k = 2; k <= 4; k++) begin
            tick();
            check("t6_rv_early", b_rv, 0);
        end
        tick();
        check("t6_rv", b_rv, 1);
        check("t6_id", b_rid, 0);
        check("t6_res", b_rres, 8'h30);
        check("t6_st", b_rst, 4'h0);
        tick();
        check("t6_done_busy", b_busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
